reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
Core measurement stage of the reaction-time tester, directly upstream of the binary-to-BCD converter.
- On a start press, waits a pseudo-random delay, lights the stimulus LED, then counts milliseconds until the react press.
- Presents the count as a 10-bit binary result, which drives the converter's 10-bit input unchanged.
- Flags false starts (react pressed before the LED) and timeouts (no press within 999 ms).

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; prescaler divide TICK_DIV = CLK_FREQ_HZ/1000.
MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay.
MAX_MS, 999, saturation/timeout value of the result; must be below 1024.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  debounced, clk-synchronous start button level; rising edge used
react  input  1  debounced, clk-synchronous react button level; rising edge used
led  output  1  stimulus LED, high while measuring
result  output  10  reaction time in ms, 0..MAX_MS, binary; feeds converter
result_valid  output  1  one-cycle pulse when a result (normal or timeout) is captured
too_early  output  1  sticky false-start flag
timeout  output  1  sticky timeout flag
busy  output  1  high in WAIT and MEASURE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; led=0, result=0, result_valid=0, too_early=0, timeout=0, busy=0; prescaler=0, ms counter=0, delay counter=0; LFSR=16'hACE1. Reset mid-trial aborts the trial immediately.
- Edge detect: registered copies of start/react. A rise is "current=1, previous=0". Previous registers reset to 1, so a button held through reset gives no event.
- LFSR: 16-bit maximal Fibonacci (taps 16,14,13,11), advances every cycle, never zero.
- Prescaler: counts 0..TICK_DIV-1. ms_tick=1 in the cycle it equals TICK_DIV-1, then it wraps. Cleared to 0 on every entry to WAIT or MEASURE.
- States: IDLE, WAIT, MEASURE, DONE, FOUL.
- IDLE/DONE/FOUL, on start rise: go to WAIT; clear too_early and timeout; delay = MIN_DELAY_MS + LFSR[10:0] (12-bit, 1000..3047 ms); result held until the next capture.
- WAIT (busy=1, led=0):
  - react rise -> FOUL, too_early=1, result=0.
  - Otherwise, on ms_tick, delay decrements. A tick with delay==1 -> MEASURE, with led=1, ms counter=0 and prescaler cleared.
  - React rise and the final tick in the same cycle -> FOUL wins.
- MEASURE (busy=1, led=1):
  - On ms_tick, ms counter increments.
  - react rise -> DONE, result = counter value before any same-cycle increment, result_valid=1 for one cycle.
  - Tick taking the counter to MAX_MS with no react -> DONE, result=MAX_MS, timeout=1, result_valid pulse.
  - A react exactly on that tick gives result=MAX_MS-1, timeout=0.
- DONE/FOUL: led=0, busy=0, outputs held.
- start rise during WAIT or MEASURE: ignored. react rise in IDLE/DONE/FOUL: ignored.
- Latency: result, result_valid and flags update on the clock edge following the qualifying react edge.

Decomposition:
- Shared package: state enum (IDLE, WAIT, MEASURE, DONE, FOUL), LFSR seed 16'hACE1, result width 10.
- Sub-module ms_tick_gen: parameter TICK_DIV; ports clk, rst_n, clr, tick.
- Edge detection and the FSM stay inline.

Test Plan:
All scenarios use CLK_FREQ_HZ=4000 (TICK_DIV=4) and MIN_DELAY_MS=2.
1. Reset with start=react=1 held, then release reset -> all outputs 0, state IDLE, no spurious trial.
2. Start rise, wait for led=1, react after 37 ticks -> result=37, single-cycle result_valid, led=0, timeout=too_early=0.
3. Start rise, react rise during WAIT -> too_early=1, result=0, led never asserted, no result_valid.
4. Start rise, no react after led=1 -> exactly 999 ticks later result=999, timeout=1, result_valid pulse.
5. React rise coincident with a ms_tick in MEASURE at count 12 -> result=12. React coincident with the final WAIT tick -> FOUL.
6. rst_n pulse low while led=1 -> led=0 asynchronously, state IDLE. A new start then completes a normal trial, and its delay (in ms ticks) lies between 2 and 2049.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-time measurement stage.
// Holds the FSM state encoding, LFSR seed/step and the result/delay widths.
package reaction_timer_pkg;

    localparam int RESULT_W = 10;
    localparam int DELAY_W  = 12;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        MEASURE,
        DONE,
        FOUL
    } state_t;

    // Maximal-length Fibonacci step, taps 16,14,13,11; stays non-zero from a non-zero seed.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/reaction_timer_ms_tick_gen.sv
// Millisecond prescaler: free-running 0..TICK_DIV-1 counter, tick while at the last count.
// A clear restarts the count so the first tick lands a full period after it.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time measurement: random pre-stimulus delay, then millisecond count until react.
// Produces a 10-bit binary result plus sticky false-start and timeout flags.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_MS       = 999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                react,
    output logic                led,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic                too_early,
    output logic                timeout,
    output logic                busy
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;

    localparam logic [RESULT_W-1:0] MAX_CNT   = RESULT_W'(MAX_MS);
    localparam logic [RESULT_W-1:0] MAX_CNT_1 = RESULT_W'(MAX_MS - 1);
    localparam logic [DELAY_W-1:0]  MIN_DELAY = DELAY_W'(MIN_DELAY_MS);
    localparam logic [DELAY_W-1:0]  ONE_MS    = DELAY_W'(1);

    state_t                state;
    logic                  start_q;
    logic                  react_q;
    logic                  start_rise;
    logic                  react_rise;
    logic [15:0]           lfsr;
    logic [DELAY_W-1:0]    delay;
    logic [RESULT_W-1:0]   ms_cnt;
    logic                  ms_tick;
    logic                  tick_clr;
    logic                  enter_wait;
    logic                  enter_measure;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (ms_tick)
    );

    // Previous-level registers reset high so a button held through reset is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b1;
            react_q <= 1'b1;
            lfsr    <= LFSR_SEED;
        end else begin
            start_q <= start;
            react_q <= react;
            lfsr    <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        start_rise    = start & ~start_q;
        react_rise    = react & ~react_q;
        enter_wait    = start_rise && (state == IDLE || state == DONE || state == FOUL);
        enter_measure = (state == WAIT) && !react_rise && ms_tick && (delay == ONE_MS);
        tick_clr      = enter_wait | enter_measure;
    end

    // React always beats a coincident tick: a false start wins over the last WAIT tick,
    // and a react on the final MEASURE tick reports the pre-increment count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            led          <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            too_early    <= 1'b0;
            timeout      <= 1'b0;
            delay        <= '0;
            ms_cnt       <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE, FOUL: begin
                    if (start_rise) begin
                        state     <= WAIT;
                        busy      <= 1'b1;
                        led       <= 1'b0;
                        too_early <= 1'b0;
                        timeout   <= 1'b0;
                        delay     <= MIN_DELAY + {1'b0, lfsr[10:0]};
                    end
                end
                WAIT: begin
                    if (react_rise) begin
                        state     <= FOUL;
                        busy      <= 1'b0;
                        too_early <= 1'b1;
                        result    <= '0;
                    end else if (ms_tick) begin
                        if (delay == ONE_MS) begin
                            state  <= MEASURE;
                            led    <= 1'b1;
                            ms_cnt <= '0;
                        end else begin
                            delay <= delay - ONE_MS;
                        end
                    end
                end
                MEASURE: begin
                    if (react_rise) begin
                        state        <= DONE;
                        led          <= 1'b0;
                        busy         <= 1'b0;
                        result       <= ms_cnt;
                        result_valid <= 1'b1;
                    end else if (ms_tick) begin
                        if (ms_cnt == MAX_CNT_1) begin
                            state        <= DONE;
                            led          <= 1'b0;
                            busy         <= 1'b0;
                            result       <= MAX_CNT;
                            timeout      <= 1'b1;
                            result_valid <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + RESULT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer at TICK_DIV=4, MIN_DELAY_MS=2, MAX_MS=999.
// Expected results are queued at stimulus time and popped by a negedge monitor.
module tb_reaction_timer;

    typedef struct packed {
        logic       valid;
        logic [9:0] result;
        logic       too_early;
        logic       timeout;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       react;
    logic       led;
    logic [9:0] result;
    logic       result_valid;
    logic       too_early;
    logic       timeout;
    logic       busy;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic        valid_pending = 1'b0;
    logic        te_prev = 1'b0;
    logic [15:0] lfsr_tb;

    reaction_timer #(
        .CLK_FREQ_HZ  (4000),
        .MIN_DELAY_MS (2),
        .MAX_MS       (999)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .react        (react),
        .led          (led),
        .result       (result),
        .result_valid (result_valid),
        .too_early    (too_early),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the delay source so each WAIT length can be predicted exactly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_tb <= 16'hACE1;
        else        lfsr_tb <= {lfsr_tb[14:0], lfsr_tb[15] ^ lfsr_tb[13] ^ lfsr_tb[12] ^ lfsr_tb[10]};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start = s;
        react = r;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_trial(output int d);
        d = 2 + int'(lfsr_tb[10:0]);
        applyStimulus(1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("wait_busy", busy, 1);
        checkOutput("wait_led", led, 0);
    endtask

    task automatic wait_led(output int cycles);
        cycles = 0;
        while (led !== 1'b1 && cycles < 8300) begin
            step(1);
            cycles++;
        end
    endtask

    // Called right after the edge that lit the LED; react is consumed n+1 edges later.
    task automatic press_react(input int n);
        step(n);
        applyStimulus(1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0);
        step(2);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_pending) begin
                checkOutput("valid_one_cycle", result_valid, 0);
                valid_pending = 1'b0;
            end
            if (result_valid || (too_early && !te_prev)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: output event valid=%0d result=%0d too_early=%0d, expected none",
                             result_valid, result, too_early);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_valid", result_valid, e.valid);
                    checkOutput("sb_result", result, e.result);
                    checkOutput("sb_too_early", too_early, e.too_early);
                    checkOutput("sb_timeout", timeout, e.timeout);
                end
                if (result_valid) valid_pending = 1'b1;
            end
        end
        te_prev = too_early;
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d;
        int cycles;
        int n;
        int led_seen;

        // Buttons held high through reset must not start a trial.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1);
        step(3);
        rst_n = 1'b1;
        step(20);
        checkOutput("rst_led", led, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_too_early", too_early, 0);
        checkOutput("rst_timeout", timeout, 0);
        applyStimulus(1'b0, 1'b0);
        step(3);
        checkOutput("idle_after_release", busy, 0);

        $display("[TB] normal trial, react after 37 ticks");
        start_trial(d);
        wait_led(cycles);
        checkOutput("t2_wait_len", cycles, 4 * d);
        sb.push_back('{1'b1, 10'd37, 1'b0, 1'b0});
        press_react(149);
        checkOutput("t2_led_off", led, 0);
        checkOutput("t2_busy_off", busy, 0);
        checkOutput("t2_result_held", result, 37);

        $display("[TB] false start during WAIT");
        start_trial(d);
        checkOutput("t3_result_held", result, 37);
        sb.push_back('{1'b0, 10'd0, 1'b1, 1'b0});
        step(5);
        applyStimulus(1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t3_too_early", too_early, 1);
        checkOutput("t3_result", result, 0);
        checkOutput("t3_busy", busy, 0);
        led_seen = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (led === 1'b1) led_seen = 1;
        end
        checkOutput("t3_led_never", led_seen, 0);

        $display("[TB] timeout with no react");
        start_trial(d);
        checkOutput("t4_too_early_cleared", too_early, 0);
        wait_led(cycles);
        checkOutput("t4_wait_len", cycles, 4 * d);
        sb.push_back('{1'b1, 10'd999, 1'b0, 1'b1});
        n = 0;
        while (led === 1'b1 && n < 5000) begin
            step(1);
            n++;
        end
        checkOutput("t4_measure_len", n, 3996);
        checkOutput("t4_timeout", timeout, 1);
        checkOutput("t4_busy", busy, 0);
        step(2);

        $display("[TB] react on the final MEASURE tick");
        start_trial(d);
        checkOutput("t4b_timeout_cleared", timeout, 0);
        wait_led(cycles);
        checkOutput("t4b_wait_len", cycles, 4 * d);
        sb.push_back('{1'b1, 10'd998, 1'b0, 1'b0});
        press_react(3995);
        checkOutput("t4b_timeout", timeout, 0);

        $display("[TB] react coincident with tick at count 12");
        start_trial(d);
        wait_led(cycles);
        checkOutput("t5_wait_len", cycles, 4 * d);
        sb.push_back('{1'b1, 10'd12, 1'b0, 1'b0});
        press_react(51);

        $display("[TB] react coincident with final WAIT tick");
        start_trial(d);
        sb.push_back('{1'b0, 10'd0, 1'b1, 1'b0});
        step(4 * d - 1);
        applyStimulus(1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5b_led", led, 0);
        checkOutput("t5b_too_early", too_early, 1);
        step(3);
        checkOutput("t5b_led_later", led, 0);

        $display("[TB] reset during MEASURE");
        start_trial(d);
        wait_led(cycles);
        step(10);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_led", led, 0);
        checkOutput("t6_async_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        checkOutput("t6_result", result, 0);
        checkOutput("t6_busy", busy, 0);
        start_trial(d);
        wait_led(cycles);
        checkOutput("t6_wait_len", cycles, 4 * d);
        checkOutput("t6_delay_range", (cycles % 4 == 0 && cycles >= 8 && cycles <= 8196) ? 1 : 0, 1);
        sb.push_back('{1'b1, 10'd5, 1'b0, 1'b0});
        press_react(20);

        step(5);
        checkOutput("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
